// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared mode, direction and state encodings for shifter_seq
package shifter_pkg;

    localparam logic [1:0] MODE_LOGIC = 2'b00;
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;
    localparam logic [1:0] MODE_SER   = 2'b11;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shifter_step.sv
// rtl/shifter_step.sv - combinational single-position shift with selectable fill
module shifter_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             LR,
    input  logic [1:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    logic fill;

    always_comb begin
        fill       = 1'b0;
        out_bit    = 1'b0;
        next_value = value;
        if (LR == DIR_LEFT) begin
            out_bit = value[WIDTH-1];
            case (mode)
                MODE_ROT: fill = value[WIDTH-1];
                MODE_SER: fill = sin;
                default:  fill = 1'b0;
            endcase
            next_value = {value[WIDTH-2:0], fill};
        end else begin
            out_bit = value[0];
            case (mode)
                MODE_ARITH: fill = value[WIDTH-1];
                MODE_ROT:   fill = value[0];
                MODE_SER:   fill = sin;
                default:    fill = 1'b0;
            endcase
            next_value = {fill, value[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shifter_seq.sv
// rtl/shifter_seq.sv - parametrised sequential shifter with multi-step command handshake
module shifter_seq
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             LR,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic             shift_en,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

    state_t             state, state_nxt;
    logic [AMT_W-1:0]   count, count_nxt;
    logic               lat_lr, lat_lr_nxt;
    logic [1:0]         lat_mode, lat_mode_nxt;
    logic               lat_sin, lat_sin_nxt;
    logic [WIDTH-1:0]   dout_nxt;
    logic               sout_nxt, busy_nxt, done_nxt;

    logic               step_lr, step_sin, step_out;
    logic [1:0]         step_mode;
    logic [WIDTH-1:0]   step_value;
    logic [AMT_W-1:0]   amt_sat;

    // A running command must not see live control changes, so it steps with the latched copy.
    assign step_lr   = (state == ST_SHIFT) ? lat_lr   : LR;
    assign step_mode = (state == ST_SHIFT) ? lat_mode : mode;
    assign step_sin  = (state == ST_SHIFT) ? lat_sin  : sin;
    assign amt_sat   = (amt > WIDTH_AMT) ? WIDTH_AMT : amt;

    shifter_step #(.WIDTH(WIDTH)) u_step (
        .value      (dout),
        .LR         (step_lr),
        .mode       (step_mode),
        .sin        (step_sin),
        .next_value (step_value),
        .out_bit    (step_out)
    );

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        lat_lr_nxt   = lat_lr;
        lat_mode_nxt = lat_mode;
        lat_sin_nxt  = lat_sin;
        dout_nxt     = dout;
        sout_nxt     = sout;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    dout_nxt = din;
                end else if (start) begin
                    lat_lr_nxt   = LR;
                    lat_mode_nxt = mode;
                    lat_sin_nxt  = sin;
                    count_nxt    = amt_sat;
                    if (amt_sat == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_SHIFT;
                        busy_nxt  = 1'b1;
                    end
                end else if (shift_en) begin
                    dout_nxt = step_value;
                    sout_nxt = step_out;
                end
            end
            ST_SHIFT: begin
                if (load) begin
                    dout_nxt  = din;
                    count_nxt = '0;
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    dout_nxt  = step_value;
                    sout_nxt  = step_out;
                    count_nxt = count - 1'b1;
                    if (count == AMT_W'(1)) begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            lat_lr   <= 1'b0;
            lat_mode <= MODE_LOGIC;
            lat_sin  <= 1'b0;
            dout     <= '0;
            sout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            lat_lr   <= lat_lr_nxt;
            lat_mode <= lat_mode_nxt;
            lat_sin  <= lat_sin_nxt;
            dout     <= dout_nxt;
            sout     <= sout_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_shifter_seq.sv
// tb/tb_shifter_seq.sv - scoreboard bench for shifter_seq
module tb_shifter_seq;

    localparam int WIDTH = 8;
    localparam int AMT_W = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             load = 1'b0;
    logic             LR = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             sin = 1'b0;
    logic             shift_en = 1'b0;
    logic             start = 1'b0;
    logic [AMT_W-1:0] amt = '0;
    logic [WIDTH-1:0] dout;
    logic             sout, busy, done;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [WIDTH:0] sb_q[$];
    logic [WIDTH-1:0] cur_v;
    logic             cur_s;

    shifter_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .load(load), .LR(LR), .mode(mode),
        .sin(sin), .shift_en(shift_en), .start(start), .amt(amt),
        .dout(dout), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] v, input logic so,
                                             input int n_in, input logic l,
                                             input logic [1:0] m, input logic s);
        int n;
        logic f;
        n = (n_in > WIDTH) ? WIDTH : n_in;
        for (int k = 0; k < n; k++) begin
            if (l) begin
                so = v[WIDTH-1];
                f  = (m == 2'b10) ? v[WIDTH-1] : (m == 2'b11) ? s : 1'b0;
                v  = {v[WIDTH-2:0], f};
            end else begin
                so = v[0];
                f  = (m == 2'b01) ? v[WIDTH-1] : (m == 2'b10) ? v[0] : (m == 2'b11) ? s : 1'b0;
                v  = {f, v[WIDTH-1:1]};
            end
        end
        return {so, v};
    endfunction

    task automatic do_load(input logic [WIDTH-1:0] d);
        load = 1'b1;
        din  = d;
        tick();
        load = 1'b0;
        check("load_dout", dout, d);
    endtask

    // Drives one command, scrambles live controls while it runs, returns on the done sample.
    task automatic run_cmd(input int a, input logic l, input logic [1:0] m, input logic s,
                           input logic [WIDTH:0] exp);
        int busy_cycles, guard, exp_busy;
        logic [WIDTH:0] e;
        sb_q.push_back(exp);
        exp_busy = (a > WIDTH) ? WIDTH : a;
        start = 1'b1;
        amt   = AMT_W'(a);
        LR    = l;
        mode  = m;
        sin   = s;
        tick();
        start = 1'b0;
        LR    = ~l;
        mode  = m ^ 2'b01;
        sin   = ~s;
        busy_cycles = 0;
        guard = 0;
        while (!done && guard < 100) begin
            if (busy) busy_cycles++;
            tick();
            guard++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
        check("busy_cycles", busy_cycles, exp_busy);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        e = sb_q.pop_front();
        check("cmd_dout", dout, e[WIDTH-1:0]);
        check("cmd_sout", {63'd0, sout}, {63'd0, e[WIDTH]});
    endtask

    task automatic done_drops();
        tick();
        check("done_pulse", {63'd0, done}, 64'd0);
    endtask

    initial begin
        #1;
        check("rst_dout", dout, 0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        do_load(8'h55);
        start = 1'b1; amt = 4'd5; LR = 1'b1; mode = 2'b00;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dout", dout, 0);
        check("midrst_sout", {63'd0, sout}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_done", {63'd0, done}, 64'd0);

        do_load(8'hA5);
        check("load_busy", {63'd0, busy}, 64'd0);

        do_load(8'b1001_0110);
        shift_en = 1'b1; LR = 1'b1; mode = 2'b00;
        repeat (3) tick();
        shift_en = 1'b0;
        check("legacy_dout", dout, 8'b1011_0000);
        check("legacy_sout", {63'd0, sout}, 64'd0);

        do_load(8'h96);
        run_cmd(3, 1'b0, 2'b01, 1'b0, {1'b1, 8'hF2});
        done_drops();

        do_load(8'h3C);
        run_cmd(15, 1'b1, 2'b10, 1'b0, {1'b0, 8'h3C});
        done_drops();
        run_cmd(0, 1'b1, 2'b10, 1'b0, {1'b0, 8'h3C});
        done_drops();

        do_load(8'hFF);
        start = 1'b1; amt = 4'd6; LR = 1'b1; mode = 2'b11; sin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; amt = 4'd1;
        tick();
        start = 1'b0;
        check("ign_busy", {63'd0, busy}, 64'd1);
        check("ign_dout", dout, 8'hFC);
        load = 1'b1; din = 8'h11;
        tick();
        load = 1'b0;
        check("abort_dout", dout, 8'h11);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        repeat (6) begin
            tick();
            check("abort_no_done", {63'd0, done}, 64'd0);
        end

        do_load(8'h00);
        run_cmd(4, 1'b0, 2'b11, 1'b1, {1'b0, 8'hF0});
        done_drops();

        do_load(8'h80);
        run_cmd(9, 1'b0, 2'b01, 1'b0, {1'b1, 8'hFF});
        done_drops();
        do_load(8'hA5);
        run_cmd(8, 1'b1, 2'b00, 1'b0, {1'b1, 8'h00});
        done_drops();

        cur_v = $urandom_range(0, 255);
        do_load(cur_v);
        cur_s = sout;
        for (int i = 0; i < 16; i++) begin
            int a;
            logic l, s;
            logic [1:0] m;
            logic [WIDTH:0] r;
            a = $urandom_range(0, 10);
            l = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            m = 2'($urandom_range(0, 3));
            r = model(cur_v, cur_s, a, l, m, s);
            run_cmd(a, l, m, s, r);
            cur_v = r[WIDTH-1:0];
            cur_s = r[WIDTH];
        end
        done_drops();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
